// File: rtl/cfu_router_pkg.sv
// Shared types and constants for the CFU command router.
// The in-flight tag holds the accelerator index and an unmapped flag that marks commands answered with the error word.
package cfu_router_pkg;

  localparam int MAX_ACCEL = 16;
  localparam int TAG_SEL_W = $clog2(MAX_ACCEL);

  localparam logic [31:0] DEF_ERR_RSP = 32'hDEAD_BEEF;

  typedef struct packed {
    logic                 unmapped;
    logic [TAG_SEL_W-1:0] sel;
  } tag_t;

  localparam int TAG_W = $bits(tag_t);

  // The extra MSB tells full apart from empty when the address bits are equal.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cfu_order_fifo.sv
// Synchronous FIFO that reports count, full and empty.
// The pointers are one bit wider than the address and wrap on their own. The head word can be read as soon as it is written.
module cfu_order_fifo
  import cfu_router_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int PTR_W = ptr_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [PTR_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int AW = PTR_W - 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/cfu_cmd_router.sv
// Routes CPU custom-instruction commands to NUM_ACCEL accelerators, selected by the top function-ID bits.
// Responses go back to the CPU in issue order through a registered output stage.
module cfu_cmd_router
  import cfu_router_pkg::*;
#(
  parameter int               NUM_ACCEL   = 2,
  parameter int               FID_W       = 10,
  parameter int               SEL_W       = 1,
  parameter int               DATA_W      = 32,
  parameter int               ORDER_DEPTH = 4,
  parameter logic [DATA_W-1:0] ERR_RSP    = DEF_ERR_RSP
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cmd_valid,
  input  logic [FID_W-1:0]            cmd_function_id,
  input  logic [DATA_W-1:0]           cmd_inputs_0,
  input  logic [DATA_W-1:0]           cmd_inputs_1,
  output logic                        cmd_ready,
  output logic                        cmd_int,
  output logic                        rsp_valid,
  output logic [DATA_W-1:0]           rsp_outputs_0,
  input  logic                        rsp_ready,
  output logic [NUM_ACCEL-1:0]        acc_cmd_valid,
  output logic [FID_W-1:0]            acc_cmd_function_id,
  output logic [DATA_W-1:0]           acc_cmd_inputs_0,
  output logic [DATA_W-1:0]           acc_cmd_inputs_1,
  input  logic [NUM_ACCEL-1:0]        acc_cmd_ready,
  input  logic [NUM_ACCEL-1:0]        acc_rsp_valid,
  input  logic [NUM_ACCEL*DATA_W-1:0] acc_rsp_outputs_0,
  output logic [NUM_ACCEL-1:0]        acc_rsp_ready,
  input  logic [NUM_ACCEL-1:0]        acc_int,
  output logic                        unmapped_seen
);

  localparam int PTR_W = ptr_w(ORDER_DEPTH);

  logic [SEL_W-1:0]     sel;
  logic                 mapped;
  logic [NUM_ACCEL-1:0] sel_oh;
  logic [NUM_ACCEL-1:0] head_oh;
  logic                 sel_ready;
  logic                 push, pop, load_ok, head_go;
  logic                 fifo_full, fifo_empty;
  logic [PTR_W-1:0]     fifo_count;
  tag_t                 push_tag, head_tag;
  logic [DATA_W-1:0]    head_data;

  assign sel    = cmd_function_id[FID_W-1 -: SEL_W];
  assign mapped = (int'(sel) < NUM_ACCEL);

  assign acc_cmd_function_id = cmd_function_id;
  assign acc_cmd_inputs_0    = cmd_inputs_0;
  assign acc_cmd_inputs_1    = cmd_inputs_1;

  assign load_ok = ~rsp_valid | rsp_ready;
  assign head_go = ~fifo_empty & load_ok;

  for (genvar i = 0; i < NUM_ACCEL; i++) begin : g_acc
    assign sel_oh[i]        = (int'(sel) == i);
    assign head_oh[i]       = ~head_tag.unmapped & (head_tag.sel == TAG_SEL_W'(i));
    assign acc_cmd_valid[i] = cmd_valid & mapped & ~fifo_full & sel_oh[i];
    // Accelerators that are not at the head stay stalled until their turn comes.
    assign acc_rsp_ready[i] = head_go & head_oh[i];
  end

  assign sel_ready = |(acc_cmd_ready & sel_oh);
  assign cmd_ready = ~fifo_full & (mapped ? sel_ready : 1'b1);
  assign push      = cmd_valid & cmd_ready;

  always_comb begin
    push_tag          = '0;
    push_tag.unmapped = ~mapped;
    push_tag.sel      = TAG_SEL_W'(sel);
  end

  always_comb begin
    head_data = ERR_RSP;
    for (int i = 0; i < NUM_ACCEL; i++)
      if (head_oh[i]) head_data = acc_rsp_outputs_0[i*DATA_W +: DATA_W];
  end

  assign pop = head_go & (head_tag.unmapped | |(acc_rsp_valid & acc_rsp_ready));

  cfu_order_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (ORDER_DEPTH)
  ) u_order (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (push_tag),
    .pop   (pop),
    .rdata (head_tag),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A reload in the same cycle as rsp_ready keeps rsp_valid high, which gives one response per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid     <= 1'b0;
      rsp_outputs_0 <= '0;
      cmd_int       <= 1'b0;
      unmapped_seen <= 1'b0;
    end else begin
      if (pop) begin
        rsp_valid     <= 1'b1;
        rsp_outputs_0 <= head_data;
      end else if (rsp_ready) begin
        rsp_valid     <= 1'b0;
      end
      cmd_int <= |acc_int;
      if (push & ~mapped) unmapped_seen <= 1'b1;
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (reset)
    int'(fifo_count) <= ORDER_DEPTH);

endmodule
